// File: rtl/bus_source_arbiter.sv
// Round-robin arbiter in front of the 32-to-5 bus-select encoder.
// It issues one registered one-hot grant at a time, with a bounded hold window and an idle gap between owners.
module bus_source_arbiter #(
   parameter int N       = 32,
   parameter int TIMEOUT = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic [4:0]   grant_idx,
   output logic         grant_valid,
   output logic         timeout_err
);

   localparam logic [7:0]   HOLD_MAX = 8'(TIMEOUT);
   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, GRANT} state_t;

   state_t       state_q;
   logic [4:0]   rr_ptr_q;
   logic [7:0]   hold_cnt_q;
   logic [N-1:0] grant_q;
   logic [4:0]   grant_idx_q;
   logic         grant_valid_q;
   logic         timeout_err_q;

   logic [4:0]   sel_idx_d;
   logic [4:0]   probe_idx;

   // The scan runs from the highest offset down, so the source closest to rr_ptr wins.
   always_comb begin
      sel_idx_d = rr_ptr_q;
      probe_idx = rr_ptr_q;
      for (int i = N - 1; i >= 0; i--) begin
         probe_idx = rr_ptr_q + 5'(i);
         if (req[probe_idx]) begin
            sel_idx_d = probe_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         hold_cnt_q    <= '0;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  grant_q       <= ONE_HOT0 << sel_idx_d;
                  grant_idx_q   <= sel_idx_d;
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= 8'd1;
                  state_q       <= GRANT;
               end
            end
            GRANT: begin
               // A done on the timeout edge counts as a clean release.
               if (done || (hold_cnt_q == HOLD_MAX)) begin
                  grant_q       <= '0;
                  grant_idx_q   <= '0;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= '0;
                  rr_ptr_q      <= grant_idx_q + 5'd1;
                  state_q       <= IDLE;
                  if (!done) begin
                     timeout_err_q <= 1'b1;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter: directed scenarios with constant expectations,
// followed by randomized traffic checked against a transaction-level owner/pointer model.
module tb_bus_source_arbiter;

   localparam int TIMEOUT = 8;

   logic        clk;
   logic        clr;
   logic [31:0] req;
   logic        done;
   logic [31:0] grant;
   logic [4:0]  grant_idx;
   logic        grant_valid;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   bus_source_arbiter #(.N(32), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .clr         (clr),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the bus (-1 = nobody), where the next search starts,
   // how long the owner has held it, and whether a forced release ever happened.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_err   = 1'b0;

   always @(posedge clk) begin
      if (clr) begin
         m_owner <= -1;
         m_ptr   <= 0;
         m_held  <= 0;
         m_err   <= 1'b0;
      end else if (m_owner < 0) begin
         if (req != 32'h0) begin
            automatic int pick = -1;
            for (int k = 0; k < 32; k++) begin
               if (pick < 0 && req[(m_ptr + k) % 32]) pick = (m_ptr + k) % 32;
            end
            m_owner <= pick;
            m_held  <= 1;
         end
      end else if (done || m_held >= TIMEOUT) begin
         m_owner <= -1;
         m_ptr   <= (m_owner + 1) % 32;
         if (!done) m_err <= 1'b1;
      end else begin
         m_held <= m_held + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clr  = 1'b1;
      req  = 32'h0;
      done = 1'b0;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      clr  = 1'b1;
      req  = 32'hFFFF_FFFF;
      done = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (grant !== 32'h0 || grant_idx !== 5'd0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got grant=%h idx=%0d vld=%b terr=%b want 0/0/0/0",
                     c, grant, grant_idx, grant_valid, timeout_err);
         end
      end
      clr = 1'b0;
      tick();
      checks++;
      if (grant !== 32'h1 || grant_idx !== 5'd0 || grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant got grant=%h idx=%0d vld=%b want 00000001/0/1",
                  grant, grant_idx, grant_valid);
      end
      done = 1'b1;
      req  = 32'h0;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 32'h0 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got grant=%h vld=%b want 0/0", grant, grant_valid);
      end
   endtask

   task automatic test_single();
      req = 32'h0000_0100;
      tick();
      checks++;
      if (grant !== 32'h100 || grant_idx !== 5'd8 || grant_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_grant got grant=%h idx=%0d vld=%b want 00000100/8/1", grant, grant_idx, grant_valid);
      end
      req = 32'h0;
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 32'h0 || grant_idx !== 5'd0 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_release got grant=%h idx=%0d vld=%b want 0/0/0", grant, grant_idx, grant_valid);
      end
      // Pointer is now 9, so source 9 beats source 8.
      req = 32'h0000_0300;
      tick();
      checks++;
      if (grant !== 32'h200 || grant_idx !== 5'd9) begin
         errors++;
         $display("FAIL single_ptr9 got grant=%h idx=%0d want 00000200/9", grant, grant_idx);
      end
      req  = 32'h0;
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_seq [5] = '{32'h1, 32'h2, 32'h8000_0000, 32'h1, 32'h2};
      logic [4:0]  exp_idx [5] = '{5'd0, 5'd1, 5'd31, 5'd0, 5'd1};
      do_clear();
      req = 32'h8000_0003;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (grant !== exp_seq[i] || grant_idx !== exp_idx[i]) begin
            errors++;
            $display("FAIL rr_grant step=%0d got grant=%h idx=%0d want %h/%0d",
                     i, grant, grant_idx, exp_seq[i], exp_idx[i]);
         end
         done = 1'b1;
         tick();
         done = 1'b0;
         checks++;
         if (grant !== 32'h0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap step=%0d got grant=%h vld=%b want 0/0", i, grant, grant_valid);
         end
      end
      req = 32'h0;
   endtask

   task automatic test_timeout();
      int held = 0;
      do_clear();
      req = 32'h10;
      tick();
      while (grant === 32'h10 && held < 20) begin
         held++;
         tick();
      end
      req = 32'h0;
      checks++;
      if (held != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_len got %0d cycles want %0d", held, TIMEOUT);
      end
      checks++;
      if (grant !== 32'h0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_flag got grant=%h terr=%b want 0/1", grant, timeout_err);
      end
      // Flag is sticky across further idle cycles and a clean transfer.
      req = 32'h1;
      tick();
      done = 1'b1;
      req  = 32'h0;
      tick();
      done = 1'b0;
      tick();
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky got terr=%b want 1", timeout_err);
      end
      do_clear();
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear got terr=%b want 0", timeout_err);
      end
   endtask

   task automatic test_simultaneous();
      do_clear();
      // Done lands on exactly the edge where the hold count reaches TIMEOUT.
      req = 32'h10;
      tick();
      req = 32'h0;
      for (int c = 0; c < TIMEOUT - 1; c++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (grant !== 32'h0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL simul_done_timeout got grant=%h terr=%b want 0/0", grant, timeout_err);
      end
      // Dropped request does not release the grant.
      req = 32'h20;
      tick();
      req = 32'h0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (grant !== 32'h20 || grant_idx !== 5'd5) begin
            errors++;
            $display("FAIL simul_req_drop cyc=%0d got grant=%h idx=%0d want 00000020/5", c, grant, grant_idx);
         end
      end
      done = 1'b1;
      tick();
      // Done held into IDLE must not disturb state or pointer (now 6).
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (grant !== 32'h0 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_done_idle cyc=%0d got grant=%h vld=%b want 0/0", c, grant, grant_valid);
         end
      end
      done = 1'b0;
      req  = 32'h41;
      tick();
      checks++;
      if (grant !== 32'h40 || grant_idx !== 5'd6) begin
         errors++;
         $display("FAIL simul_ptr_kept got grant=%h idx=%0d want 00000040/6", grant, grant_idx);
      end
      req  = 32'h0;
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_clear();
      req = 32'h400;
      tick();
      checks++;
      if (grant !== 32'h400) begin
         errors++;
         $display("FAIL midrst_grant got grant=%h want 00000400", grant);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (grant !== 32'h0 || grant_idx !== 5'd0 || grant_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear got grant=%h idx=%0d vld=%b want 0/0/0", grant, grant_idx, grant_valid);
      end
      req = 32'h401;
      tick();
      checks++;
      if (grant !== 32'h1 || grant_idx !== 5'd0) begin
         errors++;
         $display("FAIL midrst_ptr0 got grant=%h idx=%0d want 00000001/0", grant, grant_idx);
      end
      req  = 32'h0;
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] exp_grant;
      logic [4:0]  exp_idx;
      int          bad = 0;
      do_clear();
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0:       req = 32'h0;
            1:       req = 32'h1 << $urandom_range(0, 31);
            2:       req = $urandom;
            default: req = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
         endcase
         done = ($urandom_range(0, 3) == 0);
         clr  = ($urandom_range(0, 199) == 0);
         tick();
         exp_grant = (m_owner < 0) ? 32'h0 : (32'h1 << m_owner);
         exp_idx   = (m_owner < 0) ? 5'd0 : 5'(m_owner);
         checks++;
         if (grant !== exp_grant || grant_idx !== exp_idx || grant_valid !== (m_owner >= 0)
             || timeout_err !== m_err || $countones(grant) > 1) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cyc=%0d got grant=%h idx=%0d vld=%b terr=%b want %h/%0d/%b/%b",
                        c, grant, grant_idx, grant_valid, timeout_err,
                        exp_grant, exp_idx, (m_owner >= 0), m_err);
         end
      end
      clr  = 1'b0;
      req  = 32'h0;
      done = 1'b0;
   endtask

   initial begin
      clr  = 1'b1;
      req  = 32'h0;
      done = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 32-to-5 bus-select encoder.
- Collects up to 32 register/unit "drive bus" requests and issues exactly one one-hot grant at a time.
- Holds each grant for a bounded transfer window; the grant vector feeds the encoder input, and grant_idx is a registered binary copy for debug/compare.

Parameters:
- N, 32, number of request sources; fixed at 32 to match the encoder width.
- TIMEOUT, 8, maximum GRANT cycles before a forced release (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  synchronous, active-high reset.
- req  input  32  per-source bus request; bit k = source k.
- done  input  1  current owner finished its transfer; sampled only in GRANT.
- grant  output  32  one-hot grant, or all-zero when no grant is active; drives the encoder.
- grant_idx  output  5  binary index of the granted source; 0 when idle.
- grant_valid  output  1  high while grant is non-zero.
- timeout_err  output  1  sticky flag: a grant was force-released.

Behaviour:
- Single clock domain. All outputs are registered.
- Reset (clr high at a clock edge), which overrides everything including a mid-transfer state:
  - state = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, timeout_err = 0.
  - rr_ptr = 0, hold_cnt = 0.
- States: IDLE, GRANT.
- IDLE:
  - If req == 0, remain in IDLE with outputs at 0.
  - Else select the first set bit of req searching upward from rr_ptr and wrapping 31 -> 0. Example: with rr_ptr = 30, search order is 30, 31, 0, 1, ...
  - At the next edge: grant = 1 << k, grant_idx = k, grant_valid = 1, hold_cnt = 1, state = GRANT.
  - Latency: req sampled at edge t produces grant visible after edge t+1 (one cycle).
- GRANT:
  - grant is held constant regardless of req changes; a dropped req does not release the grant.
  - If done = 1 at an edge:
    - grant = 0, grant_valid = 0, grant_idx = 0.
    - rr_ptr = (k + 1) mod 32, so 31 wraps to 0.
    - state = IDLE.
  - Else if hold_cnt == TIMEOUT: perform the same release as done, and additionally set timeout_err = 1.
  - Else hold_cnt increments by 1.
  - done and timeout reached on the same edge: treat as a normal done release; timeout_err is not set.
- Back-to-back grants: at least one IDLE cycle with grant = 0 between owners. This guarantees the encoder never sees two bits set, even transiently. Minimum spacing is done edge -> new grant after 2 edges.
- grant is always one-hot or zero; popcount(grant) <= 1 at every edge.
- timeout_err clears only on clr.
- hold_cnt width is 8 bits.
- done asserted in IDLE is ignored.
- req bits may change at any edge; only the value sampled in IDLE matters.

Test Plan:
- Reset: drive clr high for 2 cycles with req = 32'hFFFF_FFFF -> grant = 0, grant_idx = 0, grant_valid = 0, timeout_err = 0 throughout; first grant is 32'h1 one cycle after clr drops.
- Single request: req = 32'h0000_0100 in IDLE -> grant = 32'h100 and grant_idx = 8 one edge later; done pulse after 3 cycles -> grant = 0 on the next edge, rr_ptr = 9.
- Round-robin fairness: hold req = 32'h8000_0003 with done pulsed on every grant -> grant sequence is 32'h1, 32'h2, 32'h8000_0000, 32'h1, ...; grant = 0 for one cycle between each; idx 31 wraps the pointer to 0.
- Timeout: req = 32'h10, done never asserted, TIMEOUT = 8 -> grant = 32'h10 for exactly 8 cycles, then 0; timeout_err = 1 and stays 1 until clr.
- Simultaneous events:
  - done on the same edge as hold_cnt == TIMEOUT -> release with timeout_err = 0.
  - Dropping req mid-GRANT -> grant unchanged until done.
  - done asserted in IDLE -> no state change.
- Reset mid-transfer: clr asserted during GRANT with grant = 32'h400 -> next edge grant = 0 and rr_ptr = 0; with req = 32'h401 after release, first grant is 32'h1.
